axi_rd_arbiter: RTL
===================

# axi_rd_arbiter

Two-requester read arbiter that sits between the instruction-fetch and data-cache refill paths and the single AXI3 read-address/read-data channel pair at the CPU top. It grants one burst at a time with round-robin fairness, drives AR, and routes R beats back to the owning requester. The write channels bypass this block.

## Interface
Parameters
- ID_W, 4: AXI ID width. arid carries the requester index, zero-extended.

Ports. "mN" denotes m0 (instruction side) and m1 (data side); each exists twice.
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- mN_req  in  1  burst request; held high with fields stable until mN_gnt
- mN_addr  in  32  burst start address
- mN_len  in  8  AXI beats minus 1
- mN_size  in  3  AXI beat size
- mN_gnt  out  1  one-cycle pulse on the AR handshake for this requester
- mN_rvalid  out  1  data beat valid for this requester
- mN_rdata  out  32  beat data
- mN_rlast  out  1  last beat
- mN_rerr  out  1  beat had rresp != OKAY; qualified by mN_rvalid
- arid  out  ID_W
- araddr  out  32
- arlen  out  8
- arsize  out  3
- arburst  out  2
- arlock  out  2
- arcache  out  4
- arprot  out  3
- arvalid  out  1
- arready  in  1  AXI read-address channel
- rid  in  ID_W
- rdata  in  32
- rresp  in  2
- rlast  in  1
- rvalid  in  1
- rready  out  1  AXI read-data channel

## Operation
- States:
  - IDLE: no burst owned.
  - ADDR: arvalid high.
  - DATA: rready high, beats forwarded.
- IDLE with any mN_req:
  - Select the owner. If both request, take the one not equal to last_gnt; otherwise take the sole requester.
  - Register mN_addr/len/size into araddr/arlen/arsize and the owner index into arid.
  - Go to ADDR.
- ADDR:
  - arvalid=1; AR fields are held constant.
  - On arvalid&arready: pulse mN_gnt for the owner, set last_gnt=owner, go to DATA.
  - Requests from either port are ignored here.
- DATA:
  - rready=1.
  - Owner's mN_rvalid = rvalid. Non-owner's mN_rvalid = 0.
  - mN_rdata = rdata, mN_rlast = rlast, mN_rerr = (rresp != 2'b00). These are combinational pass-through.
  - On rvalid&rlast, go to IDLE.
  - rid is not checked; only one burst is ever outstanding.
- Constants: arburst=2'b01 (INCR), arlock=0, arcache=0, arprot=0.
- An owner's mN_req may drop after mN_gnt. A request that stays high after its grant is treated as a new request in the next IDLE.
- A request dropped before grant (illegal) is not tracked. The latched fields are still issued.

## Timing
- Reset: state=IDLE, last_gnt=1 (m0 wins the first tie), arvalid=0, rready=0, araddr=0, arlen=0, arsize=0, arid=0, all mN_gnt/mN_rvalid=0.
- Reset asserted mid-burst clears everything immediately. arvalid and rready fall without waiting for a clock. Outstanding beats are dropped.
- Request latency:
  - mN_req high in cycle 0 while IDLE gives arvalid=1 in cycle 1.
  - arready high in cycle 1 gives mN_gnt=1 in cycle 1 and rready=1 from cycle 2.
- Beat latency: zero. mN_rvalid equals rvalid in the same cycle.
- Turnaround: the rlast handshake in cycle k gives IDLE in k+1. A pending request gives arvalid in k+2, so there is a minimum 2-cycle bubble between bursts.
- arready stalls: arvalid stays high and the fields stay stable indefinitely.
- rvalid low in DATA: hold state.
- Both ports request in the same cycle: exactly one is granted. The other is granted next, provided it is still requesting.
- arlen=0: a single beat with rlast=1 completes DATA in one handshake.

## Test plan
- Single m0 burst:
  - Stimulus: m0_req, addr=0x1c000000, len=3, size=2, arready=1, four rvalid beats 0xA0..0xA3 with rlast on the fourth.
  - Required: arid=0, arlen=3, arburst=1; m0_gnt in cycle 1; m0_rvalid ×4 with matching data; m1_rvalid never set; IDLE after the rlast beat.
- Simultaneous requests after reset:
  - Stimulus: m0 and m1 both request continuously.
  - Required: grant order m0, m1, m0, m1; arid alternates 0,1,0,1.
- Backpressure:
  - Stimulus: arready low for 5 cycles, then rvalid gaps between beats.
  - Required: arvalid stays high with araddr stable for all 5 cycles; beats are forwarded only when rvalid=1; no extra grants.
- Error response:
  - Stimulus: m1 burst of len=1; second beat has rresp=2'b10.
  - Required: m1_rerr=0 on beat 0 and 1 on beat 1; burst still completes on rlast.
- Reset mid-burst:
  - Stimulus: aresetn low during beat 2 of a len=7 burst.
  - Required: rready, arvalid and mN_rvalid are 0 immediately. After release, a new m1 request gets arid=1 with arvalid 1 cycle after the request.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin two-requester arbiter onto a single AXI3 read channel pair.
module axi_rd_arbiter #(
   parameter int ID_W = 4
) (
   input  logic            aclk,
   input  logic            aresetn,
   input  logic            m0_req,
   input  logic [31:0]     m0_addr,
   input  logic [7:0]      m0_len,
   input  logic [2:0]      m0_size,
   output logic            m0_gnt,
   output logic            m0_rvalid,
   output logic [31:0]     m0_rdata,
   output logic            m0_rlast,
   output logic            m0_rerr,
   input  logic            m1_req,
   input  logic [31:0]     m1_addr,
   input  logic [7:0]      m1_len,
   input  logic [2:0]      m1_size,
   output logic            m1_gnt,
   output logic            m1_rvalid,
   output logic [31:0]     m1_rdata,
   output logic            m1_rlast,
   output logic            m1_rerr,
   output logic [ID_W-1:0] arid,
   output logic [31:0]     araddr,
   output logic [7:0]      arlen,
   output logic [2:0]      arsize,
   output logic [1:0]      arburst,
   output logic [1:0]      arlock,
   output logic [3:0]      arcache,
   output logic [2:0]      arprot,
   output logic            arvalid,
   input  logic            arready,
   input  logic [ID_W-1:0] rid,
   input  logic [31:0]     rdata,
   input  logic [1:0]      rresp,
   input  logic            rlast,
   input  logic            rvalid,
   output logic            rready
);
   localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2;
   logic [1:0] state;
   logic       owner, last_gnt, sel;
   logic       unused_rid;
   // on a tie the requester that did not win last time goes first
   assign sel = (m0_req & m1_req) ? ~last_gnt : m1_req;
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         state    <= IDLE;
         owner    <= 1'b0;
         last_gnt <= 1'b1;
         araddr   <= '0;
         arlen    <= '0;
         arsize   <= '0;
      end else
         case (state)
            IDLE: if (m0_req | m1_req) begin
               owner  <= sel;
               araddr <= sel ? m1_addr : m0_addr;
               arlen  <= sel ? m1_len : m0_len;
               arsize <= sel ? m1_size : m0_size;
               state  <= ADDR;
            end
            ADDR: if (arready) begin
               last_gnt <= owner;
               state    <= DATA;
            end
            DATA: if (rvalid & rlast) state <= IDLE;
            default: state <= IDLE;
         endcase
   // handshake outputs decode straight from state so reset drops them asynchronously
   assign arvalid    = state == ADDR;
   assign rready     = state == DATA;
   assign arid       = ID_W'(owner);
   assign arburst    = 2'b01;
   assign arlock     = 2'b00;
   assign arcache    = 4'b0000;
   assign arprot     = 3'b000;
   assign m0_gnt     = arvalid & arready & ~owner;
   assign m1_gnt     = arvalid & arready & owner;
   assign m0_rvalid  = rready & rvalid & ~owner;
   assign m1_rvalid  = rready & rvalid & owner;
   assign m0_rdata   = rdata;
   assign m1_rdata   = rdata;
   assign m0_rlast   = rlast;
   assign m1_rlast   = rlast;
   assign m0_rerr    = rresp != 2'b00;
   assign m1_rerr    = rresp != 2'b00;
   assign unused_rid = ^rid;
endmodule
